// File: rtl/rv32i_result_dumper.sv
// Post-run result unloader: counts cycles/stall events until ecall, then streams a statistics
// header (only when RESULT_STATS_EN is defined) followed by DUMP_WORDS dmem words over valid/ready.
module rv32i_result_dumper #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int DUMP_WORDS = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecall,
  input  logic              lwstall_a,
  input  logic              lwstall_b,
  input  logic              branchstall_a,
  input  logic              branchstall_b,
  input  logic              stall,
  input  logic              bra_op_a,
  input  logic              bra_op_b,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              halted
);

  typedef enum logic [1:0] {S_RUN, S_HDR, S_DUMP, S_DONE} state_e;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DUMP_WORDS - 1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic            xfer;

  assign xfer = out_valid & out_ready;

`ifdef RESULT_STATS_EN
  logic [DATA_W-1:0] cyc_q, cyc_d, lw_q, lw_d, bb_q, bb_d, ab_q, ab_d;
  logic [1:0]        hdr_q, hdr_d;
  logic              count_en;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + DATA_W'(1) : v;
  endfunction

  // The ecall cycle itself is excluded from every counter.
  assign count_en = (state_q == S_RUN) && !ecall;

  always_comb begin
    cyc_d = sat_inc(cyc_q, count_en);
    lw_d  = sat_inc(lw_q,  count_en && (lwstall_a || lwstall_b));
    bb_d  = sat_inc(bb_q,  count_en && (branchstall_a || branchstall_b));
    ab_d  = sat_inc(ab_q,  count_en && !stall && (bra_op_a || bra_op_b));
    hdr_d = hdr_q;
    if (state_q == S_HDR && xfer) hdr_d = hdr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      lw_q  <= '0;
      bb_q  <= '0;
      ab_q  <= '0;
      hdr_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      lw_q  <= lw_d;
      bb_q  <= bb_d;
      ab_q  <= ab_d;
      hdr_q <= hdr_d;
    end
  end
`else
  wire unused_stall_inputs = &{1'b0, lwstall_a, lwstall_b, branchstall_a, branchstall_b,
                               stall, bra_op_a, bra_op_b};
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_RUN: begin
        idx_d = '0;
`ifdef RESULT_STATS_EN
        if (ecall) state_d = S_HDR;
`else
        if (ecall) state_d = S_DUMP;
`endif
      end
`ifdef RESULT_STATS_EN
      S_HDR: if (xfer && hdr_q == 2'd3) state_d = S_DUMP;
`endif
      S_DUMP: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + (ADDR_W+1)'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so they follow reset without a clock edge.
  always_comb begin
    busy      = (state_q == S_HDR) || (state_q == S_DUMP);
    out_valid = busy;
    halted    = (state_q == S_DONE);
    out_last  = (state_q == S_DUMP) && (idx_q == LAST_IDX);
    mem_addr  = (state_q == S_DUMP) ? idx_q[ADDR_W-1:0] : '0;
    out_data  = '0;
    if (state_q == S_DUMP) out_data = mem_rdata;
`ifdef RESULT_STATS_EN
    if (state_q == S_HDR) begin
      case (hdr_q)
        2'd0:    out_data = cyc_q;
        2'd1:    out_data = lw_q;
        2'd2:    out_data = bb_q;
        default: out_data = ab_q;
      endcase
    end
`endif
  end

endmodule

// File: doc/rv32i_result_dumper.md
# rv32i_result_dumper

Post-run result unloader for the dual-issue rv32i contest system. Counts cycles and pipeline stall events while the core runs. On `ecall` it freezes the counters, takes over data-memory port A, and streams a statistics header and the first `DUMP_WORDS` words of dmem over a valid/ready interface. It sits downstream of `rv32i` and `dmem` and replaces the bench-only counting and file dump with synthesizable logic.

## Interface
- `DATA_W`, 32, word width of counters, dmem data and the output stream
- `ADDR_W`, 16, dmem word-address width (byte address bits [17:2])
- `DUMP_WORDS`, 200, number of dmem words streamed; legal range 1..2^ADDR_W

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ecall`  in  1  core ecall indication
- `lwstall_a`, `lwstall_b`  in  1 each  load-use stall flags
- `branchstall_a`, `branchstall_b`  in  1 each  pre-branch stall flags
- `stall`  in  1  global pipeline stall
- `bra_op_a`, `bra_op_b`  in  1 each  branch in decode, lanes a/b
- `busy`  out  1  dumper owns dmem port A; integration gates the core's `we_a`/`we_b` and address-A mux on this
- `mem_addr`  out  ADDR_W  dmem port-A word address
- `mem_rdata`  in  DATA_W  dmem port-A read data (combinational read)
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  sink ready
- `out_data`  out  DATA_W  stream word
- `out_last`  out  1  final word of the stream
- `halted`  out  1  dump finished; sticky until reset

## Operation
- The block has four states:
  - RUN: dumper is idle and counters are live.
  - HDR: 4 header words are emitted.
  - DUMP: dmem words are emitted.
  - DONE: terminal state.
- Counters in RUN, evaluated per rising edge while `ecall`=0:
  - `cyc` increments by 1.
  - `lw_c` increments if `lwstall_a|lwstall_b`.
  - `bb_c` increments if `branchstall_a|branchstall_b`.
  - `ab_c` increments if `!stall & (bra_op_a|bra_op_b)`.
  - All four counters saturate at 2^DATA_W-1.
- Events in the `ecall` cycle itself are not counted.
- RUN→HDR on the edge where `ecall`=1. The counters then freeze.
- HDR emits, in order:
  - word 0 = `cyc`
  - word 1 = `lw_c`
  - word 2 = `bb_c`
  - word 3 = `ab_c`
- HDR→DUMP after the word-3 handshake.
- DUMP emits `mem_rdata` for `mem_addr` = 0..DUMP_WORDS-1 in order.
  - `out_last`=1 only with the final word.
  - DUMP→DONE on its handshake.
- DONE:
  - `halted`=1, `busy`=0, `out_valid`=0.
  - `ecall` is ignored.
- `ecall` is ignored in HDR, DUMP and DONE.
- `busy`=1 in HDR and DUMP.
- `mem_addr` = 0 outside DUMP.

## Timing
- Reset values for all outputs: state RUN, counters 0, `busy`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `mem_addr`=0, `halted`=0.
- Reset is asynchronous. Asserting it mid-stream aborts immediately with no partial-word completion.
- `out_valid` is registered. It rises on the edge that samples `ecall`=1 (latency 1 cycle).
- Transfer rule: a word transfers on a rising edge with `out_valid & out_ready`. The index advances on that edge only.
- With `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `mem_addr` hold stable.
- `out_valid` never drops before the transfer.
- In DUMP, `out_data` = `mem_rdata` combinationally. The dmem read is asynchronous and `busy` freezes memory contents, so no extra cycle is inserted.
- With `out_ready` held at 1, one word transfers per cycle. The full stream takes 4+DUMP_WORDS cycles after the ecall edge.
- The DUMP index counter is ADDR_W+1 bits wide, so `DUMP_WORDS`=2^ADDR_W completes without wrap.

## Configuration
- `RESULT_STATS_EN` defined:
  - The counters and the HDR state are built.
  - The stream is 4 header words followed by DUMP_WORDS dmem words.
- `RESULT_STATS_EN` not defined:
  - The counters and HDR are compiled out.
  - `ecall` goes RUN→DUMP directly.
  - The stream is DUMP_WORDS words starting with mem[0].
  - Stall inputs are unused.

## Test plan
- Basic run: release reset, preload dmem[i]=i*4, `ecall` sampled on the 11th edge, no stall flags, `out_ready`=1.
  - Words: 10,0,0,0, then 0,4,…,796.
  - `out_last` on word 203; `halted`=1 the next cycle.
- OR-counting: `lwstall_a`=`lwstall_b`=1 for 3 cycles, and `branchstall_a`=1 for 2 cycles, each with `bra_op_b`=1 and `stall`=0.
  - `lw_c`=3 (OR, not sum), `bb_c`=2, `ab_c`=2.
- Same-cycle exclusion: all stall flags, `stall`=0 and `bra_op_a`=1 asserted in the `ecall` cycle only.
  - Header words 1-3 = 0.
  - A second `ecall` pulse during DUMP changes nothing.
- Backpressure: `out_ready`=0 for 5 cycles while word 5 (dmem[1]) is presented.
  - `out_data`=4 and `mem_addr`=1 stay stable.
  - No word is skipped or duplicated; total handshakes = 204.
- Reset mid-dump: assert `rst_n`=0 at word 50.
  - Outputs reach reset values without a clock edge.
  - After release, a new run restarts `cyc` from 0.
- `RESULT_STATS_EN` undefined, stimulus as the basic run:
  - First word = dmem[0]=0.
  - `out_last` on the 200th word.
